// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and default sizes for the pipeline stage buffer and its users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_stage_buf_pkg;

  // Occupancy of one stage: no entry, head only, head plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } occ_e;

  // Default payload and counter widths shared by the decoder and all stages.
  localparam int DEF_DATA_W = 128;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bus carrying one instruction's data and control payload.
// Latency: n/a (wires only).
// Backpressure: ready from the receiver; the sender holds valid/data/ctrl until ready.
// Signals: valid, ready, data[DATA_W], ctrl[CTRL_W].
// Modports: master (sender side), slave (receiver side).
interface pipe_stage_buf_if
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_buf_perf_cnt.sv
// Saturating event counter: increments by one per cycle while inc=1, sticks at all-ones.
// Latency: count reflects an increment one cycle after inc.
// Backpressure: none.
// Ports: clk, rst (async, active-high), inc, cnt[CNT_W].
// Only built when PIPE_STAGE_PERF_EN is defined.
`ifdef PIPE_STAGE_PERF_EN
module pipe_stage_buf_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end
endmodule
`endif

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with 2-entry skid buffer; flush kills all held entries.
// Latency: 1 cycle from in-side transfer to out-side presentation.
// Backpressure: in_if.ready is registered and drops only when both entries are occupied.
// Ports: clk, rst (async, active-high), flush, in_if (slave), out_if (master),
//        stall_cnt/flush_cnt (perf counters; tied to 0 unless PIPE_STAGE_PERF_EN is defined).
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                CTRL_W   = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_buf_if.slave       in_if,
  pipe_stage_buf_if.master      out_if,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  occ_e              state;
  logic              in_rdy_q;
  logic              out_vld_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic in_xfer, out_xfer;
  assign in_xfer  = in_if.valid & in_rdy_q;
  assign out_xfer = out_vld_q & out_if.ready;

  assign in_if.ready  = in_rdy_q;
  assign out_if.valid = out_vld_q;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = main_ctrl;

  // Occupancy FSM. in_rdy_q/out_vld_q are updated alongside the next state so both
  // handshake outputs come straight from flops. Data regs only load on a transfer;
  // ctrl regs are forced to CTRL_NOP whenever their entry empties, so out_ctrl is
  // CTRL_NOP whenever the stage holds a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      main_data <= '0;
      main_ctrl <= CTRL_NOP;
      skid_data <= '0;
      skid_ctrl <= CTRL_NOP;
    end else if (flush) begin
      // Any same-cycle in-side transfer is discarded; a same-cycle out-side
      // transfer has already been taken by the downstream stage.
      state     <= EMPTY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      main_ctrl <= CTRL_NOP;
      skid_ctrl <= CTRL_NOP;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_data <= in_if.data;
            main_ctrl <= in_if.ctrl;
            out_vld_q <= 1'b1;
            state     <= FULL1;
          end
        end
        FULL1: begin
          if (in_xfer && out_xfer) begin
            main_data <= in_if.data;
            main_ctrl <= in_if.ctrl;
          end else if (in_xfer) begin
            skid_data <= in_if.data;
            skid_ctrl <= in_if.ctrl;
            in_rdy_q  <= 1'b0;
            state     <= FULL2;
          end else if (out_xfer) begin
            main_ctrl <= CTRL_NOP;
            out_vld_q <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL2: begin
          // in_rdy_q is low here, so only the out side can move.
          if (out_xfer) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= CTRL_NOP;
            in_rdy_q  <= 1'b1;
            state     <= FULL1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_rdy_q  <= 1'b1;
          out_vld_q <= 1'b0;
          main_ctrl <= CTRL_NOP;
          skid_ctrl <= CTRL_NOP;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc, flush_kill;
  assign stall_inc  = out_vld_q & ~out_if.ready;
  // A flush kills something unless the only held entry leaves downstream that cycle.
  assign flush_kill = flush & ((state == FULL2) | ((state == FULL1) & ~out_if.ready));

  pipe_stage_buf_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_stage_buf_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_kill),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
